// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module      : sram_port_arbiter
// Description : Two-requester arbiter and command sequencer for the RW port
//               of a 1rw1r SRAM macro, with a registered one-cycle ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int ADDR_WD  = 8,
    parameter int DATA_WD  = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                   wb_clk_i,
    input  logic                   rst_n,
    input  logic                   r0_req_i,
    input  logic                   r0_we_i,
    input  logic [ADDR_WD-1:0]     r0_addr_i,
    input  logic [DATA_WD-1:0]     r0_wdata_i,
    input  logic [DATA_WD/8-1:0]   r0_mask_i,
    output logic                   r0_ack_o,
    output logic [DATA_WD-1:0]     r0_rdata_o,
    input  logic                   r1_req_i,
    input  logic                   r1_we_i,
    input  logic [ADDR_WD-1:0]     r1_addr_i,
    input  logic [DATA_WD-1:0]     r1_wdata_i,
    input  logic [DATA_WD/8-1:0]   r1_mask_i,
    output logic                   r1_ack_o,
    output logic [DATA_WD-1:0]     r1_rdata_o,
    output logic                   sram_csb0_o,
    output logic                   sram_web0_o,
    output logic [DATA_WD/8-1:0]   sram_wmask0_o,
    output logic [ADDR_WD-1:0]     sram_addr0_o,
    output logic [DATA_WD-1:0]     sram_din0_o,
    input  logic [DATA_WD-1:0]     sram_dout0_i,
    output logic                   busy_o,
    output logic                   grant_o
);

    localparam int   c_MASK_WD    = DATA_WD / 8;
    localparam logic c_FIXED_PRI  = (ARB_MODE != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 r_state_q,  w_state_d;
    logic                   r_grant_q,  w_grant_d;
    logic                   r_rr_pri_q, w_rr_pri_d;
    logic                   r_we_q,     w_we_d;
    logic                   r_csb_q,    w_csb_d;
    logic                   r_web_q,    w_web_d;
    logic [c_MASK_WD-1:0]   r_wmask_q,  w_wmask_d;
    logic [ADDR_WD-1:0]     r_addr_q,   w_addr_d;
    logic [DATA_WD-1:0]     r_din_q,    w_din_d;
    logic                   r_ack0_q,   w_ack0_d;
    logic                   r_ack1_q,   w_ack1_d;
    logic [DATA_WD-1:0]     r_rdata0_q, w_rdata0_d;
    logic [DATA_WD-1:0]     r_rdata1_q, w_rdata1_d;
    logic                   r_busy_q,   w_busy_d;
    logic                   w_win;

    // r1 wins when alone, or on a tie when round-robin points at it.
    assign w_win = r1_req_i & (~r0_req_i | (~c_FIXED_PRI & r_rr_pri_q));

    always_comb begin
        w_state_d  = r_state_q;
        w_grant_d  = r_grant_q;
        w_rr_pri_d = r_rr_pri_q;
        w_we_d     = r_we_q;
        w_csb_d    = r_csb_q;
        w_web_d    = r_web_q;
        w_wmask_d  = r_wmask_q;
        w_addr_d   = r_addr_q;
        w_din_d    = r_din_q;
        w_ack0_d   = 1'b0;
        w_ack1_d   = 1'b0;
        w_rdata0_d = r_rdata0_q;
        w_rdata1_d = r_rdata1_q;
        case (r_state_q)
            ST_IDLE: begin
                if (r0_req_i || r1_req_i) begin
                    w_state_d  = ST_CMD;
                    w_grant_d  = w_win;
                    w_rr_pri_d = ~w_win;
                    w_we_d     = w_win ? r1_we_i : r0_we_i;
                    w_addr_d   = w_win ? r1_addr_i : r0_addr_i;
                    w_din_d    = w_win ? r1_wdata_i : r0_wdata_i;
                    w_wmask_d  = w_we_d ? (w_win ? r1_mask_i : r0_mask_i) : '0;
                    w_csb_d    = 1'b0;
                    w_web_d    = ~w_we_d;
                end
            end
            ST_CMD: begin
                w_state_d = ST_WAIT;
                w_csb_d   = 1'b1;
                w_web_d   = 1'b1;
            end
            ST_WAIT: begin
                w_state_d = ST_DONE;
                if (!r_we_q) begin
                    if (r_grant_q) w_rdata1_d = sram_dout0_i;
                    else           w_rdata0_d = sram_dout0_i;
                end
                w_ack0_d = ~r_grant_q;
                w_ack1_d = r_grant_q;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= ST_IDLE;
            r_grant_q  <= 1'b0;
            r_rr_pri_q <= 1'b0;
            r_we_q     <= 1'b0;
            r_csb_q    <= 1'b1;
            r_web_q    <= 1'b1;
            r_wmask_q  <= '0;
            r_addr_q   <= '0;
            r_din_q    <= '0;
            r_ack0_q   <= 1'b0;
            r_ack1_q   <= 1'b0;
            r_rdata0_q <= '0;
            r_rdata1_q <= '0;
            r_busy_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_grant_q  <= w_grant_d;
            r_rr_pri_q <= w_rr_pri_d;
            r_we_q     <= w_we_d;
            r_csb_q    <= w_csb_d;
            r_web_q    <= w_web_d;
            r_wmask_q  <= w_wmask_d;
            r_addr_q   <= w_addr_d;
            r_din_q    <= w_din_d;
            r_ack0_q   <= w_ack0_d;
            r_ack1_q   <= w_ack1_d;
            r_rdata0_q <= w_rdata0_d;
            r_rdata1_q <= w_rdata1_d;
            r_busy_q   <= w_busy_d;
        end
    end

    assign r0_ack_o      = r_ack0_q;
    assign r1_ack_o      = r_ack1_q;
    assign r0_rdata_o    = r_rdata0_q;
    assign r1_rdata_o    = r_rdata1_q;
    assign sram_csb0_o   = r_csb_q;
    assign sram_web0_o   = r_web_q;
    assign sram_wmask0_o = r_wmask_q;
    assign sram_addr0_o  = r_addr_q;
    assign sram_din0_o   = r_din_q;
    assign busy_o        = r_busy_q;
    assign grant_o       = r_grant_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Directed bench for sram_port_arbiter: instance 0 round-robin,
//               instance 1 fixed priority, each with its own SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req   [2][2];
    logic        we    [2][2];
    logic [7:0]  addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [3:0]  mask  [2][2];
    logic        ack   [2][2];
    logic [31:0] rdata [2][2];
    logic        csb   [2];
    logic        web   [2];
    logic        busy  [2];
    logic        grant [2];
    logic [3:0]  wm    [2];
    logic [7:0]  sa    [2];
    logic [31:0] din   [2];
    logic [31:0] dout  [2];
    logic [31:0] mem   [2][256];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        sram_port_arbiter #(.ADDR_WD(8), .DATA_WD(32), .ARB_MODE(k)) u_dut (
            .wb_clk_i      (clk),
            .rst_n         (rst_n),
            .r0_req_i      (req[k][0]),
            .r0_we_i       (we[k][0]),
            .r0_addr_i     (addr[k][0]),
            .r0_wdata_i    (wdata[k][0]),
            .r0_mask_i     (mask[k][0]),
            .r0_ack_o      (ack[k][0]),
            .r0_rdata_o    (rdata[k][0]),
            .r1_req_i      (req[k][1]),
            .r1_we_i       (we[k][1]),
            .r1_addr_i     (addr[k][1]),
            .r1_wdata_i    (wdata[k][1]),
            .r1_mask_i     (mask[k][1]),
            .r1_ack_o      (ack[k][1]),
            .r1_rdata_o    (rdata[k][1]),
            .sram_csb0_o   (csb[k]),
            .sram_web0_o   (web[k]),
            .sram_wmask0_o (wm[k]),
            .sram_addr0_o  (sa[k]),
            .sram_din0_o   (din[k]),
            .sram_dout0_i  (dout[k]),
            .busy_o        (busy[k]),
            .grant_o       (grant[k])
        );
    end

    // Macro model: command captured at the clock edge, read data registered.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!csb[k]) begin
                if (!web[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (wm[k][b]) mem[k][sa[k]][b*8 +: 8] = din[k][b*8 +: 8];
                end else begin
                    dout[k] <= mem[k][sa[k]];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lone-requester access with per-phase checks; req dropped while ack is seen.
    task automatic access(input int k, input int r, input logic w, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp);
        req[k][r] = 1'b1; we[k][r] = w; addr[k][r] = a; wdata[k][r] = d; mask[k][r] = m;
        step();
        chk("cmd_csb",   32'(csb[k]),   32'd0);
        chk("cmd_web",   32'(web[k]),   32'(!w));
        chk("cmd_addr",  32'(sa[k]),    32'(a));
        chk("cmd_wmask", 32'(wm[k]),    w ? 32'(m) : 32'd0);
        chk("cmd_grant", 32'(grant[k]), 32'(r));
        chk("cmd_busy",  32'(busy[k]),  32'd1);
        if (w) chk("cmd_din", din[k], d);
        step();
        chk("wait_csb", 32'(csb[k]),    32'd1);
        chk("wait_web", 32'(web[k]),    32'd1);
        chk("wait_ack", 32'(ack[k][r]), 32'd0);
        step();
        chk("done_ack",   32'(ack[k][r]),   32'd1);
        chk("done_other", 32'(ack[k][1-r]), 32'd0);
        if (!w) chk("done_rdata", rdata[k][r], exp);
        req[k][r] = 1'b0;
        step();
        chk("idle_ack",  32'(ack[k][r]), 32'd0);
        chk("idle_busy", 32'(busy[k]),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++) begin
                req[k][r] = 1'b0; we[k][r] = 1'b0; addr[k][r] = 8'h00;
                wdata[k][r] = 32'h0; mask[k][r] = 4'h0;
            end
        step(); step();
        rst_n = 1'b1;
        step();

        chk("rst_csb",    32'(csb[0]),      32'd1);
        chk("rst_web",    32'(web[0]),      32'd1);
        chk("rst_wmask",  32'(wm[0]),       32'd0);
        chk("rst_addr",   32'(sa[0]),       32'd0);
        chk("rst_din",    din[0],           32'd0);
        chk("rst_acks",   {30'd0, ack[0][1], ack[0][0]}, 32'd0);
        chk("rst_rdata0", rdata[0][0],      32'd0);
        chk("rst_rdata1", rdata[0][1],      32'd0);
        chk("rst_busy",   32'(busy[0]),     32'd0);
        chk("rst_grant",  32'(grant[0]),    32'd0);

        // Write then read back full word.
        access(0, 0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0);
        access(0, 0, 1'b0, 8'h10, 32'h0,        4'hF, 32'hDEADBEEF);

        // Byte mask merge, and a zero-mask write that must change nothing.
        access(0, 0, 1'b1, 8'h20, 32'h11223344, 4'hF,    32'h0);
        access(0, 0, 1'b1, 8'h20, 32'h0000AA00, 4'b0010, 32'h0);
        access(0, 0, 1'b0, 8'h20, 32'h0,        4'h0,    32'h1122AA44);
        access(0, 0, 1'b1, 8'h20, 32'hFFFFFFFF, 4'h0,    32'h0);
        access(0, 0, 1'b0, 8'h20, 32'h0,        4'h0,    32'h1122AA44);

        // Boundary addresses; r1 served last so r0 holds round-robin priority next.
        access(0, 0, 1'b1, 8'h01, 32'hA5A50001, 4'hF, 32'h0);
        access(0, 1, 1'b1, 8'hFF, 32'h5A5A00FF, 4'hF, 32'h0);
        access(0, 1, 1'b0, 8'hFF, 32'h0,        4'h0, 32'h5A5A00FF);

        // Round-robin with both requesters held high: 0,1,0,1.
        for (int r = 0; r < 2; r++) begin
            req[0][r] = 1'b1; we[0][r] = 1'b0; mask[0][r] = 4'h0;
        end
        addr[0][0] = 8'h01;
        addr[0][1] = 8'hFF;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("rr_grant", 32'(grant[0]), 32'(n % 2));
            chk("rr_addr",  32'(sa[0]),    (n % 2) ? 32'hFF : 32'h01);
            step();
            step();
            chk("rr_ack_win",  32'(ack[0][n % 2]),       32'd1);
            chk("rr_ack_lose", 32'(ack[0][1 - (n % 2)]), 32'd0);
            chk("rr_rdata", rdata[0][n % 2], (n % 2) ? 32'h5A5A00FF : 32'hA5A50001);
            if (n == 3) begin
                req[0][0] = 1'b0;
                req[0][1] = 1'b0;
            end
            step();
            chk("rr_ack_clear", {30'd0, ack[0][1], ack[0][0]}, 32'd0);
        end
        step();
        chk("rr_end_busy", 32'(busy[0]), 32'd0);

        // Late drop: r1 releases req during WAIT; access still completes once.
        req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 8'h01;
        step();
        chk("late_grant", 32'(grant[0]), 32'd1);
        step();
        req[0][1] = 1'b0;
        step();
        chk("late_ack",   32'(ack[0][1]), 32'd1);
        chk("late_rdata", rdata[0][1],    32'hA5A50001);
        step();
        step();
        chk("late_no_retry_busy", 32'(busy[0]),  32'd0);
        chk("late_no_retry_csb",  32'(csb[0]),   32'd1);
        chk("late_rdata_held",    rdata[0][1],   32'hA5A50001);

        // Fixed priority: r0 wins every tie; r1 only after r0 stops asking.
        for (int r = 0; r < 2; r++) begin
            req[1][r] = 1'b1; we[1][r] = 1'b0; mask[1][r] = 4'h0;
        end
        addr[1][0] = 8'h05;
        addr[1][1] = 8'h06;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("fx_grant", 32'(grant[1]), 32'd0);
            step();
            step();
            chk("fx_ack0", 32'(ack[1][0]), 32'd1);
            chk("fx_ack1", 32'(ack[1][1]), 32'd0);
            if (n == 2) req[1][0] = 1'b0;
            step();
        end
        step();
        chk("fx_r1_grant", 32'(grant[1]), 32'd1);
        chk("fx_r1_addr",  32'(sa[1]),    32'h06);
        step();
        step();
        chk("fx_r1_ack", 32'(ack[1][1]), 32'd1);
        req[1][1] = 1'b0;
        step();
        step();
        chk("fx_end_busy", 32'(busy[1]), 32'd0);

        // Asynchronous reset in the middle of a CMD cycle.
        req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 8'h33;
        wdata[0][1] = 32'hCAFEF00D; mask[0][1] = 4'hF;
        step();
        chk("pre_rst_csb", 32'(csb[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_csb",    32'(csb[0]),   32'd1);
        chk("arst_web",    32'(web[0]),   32'd1);
        chk("arst_busy",   32'(busy[0]),  32'd0);
        chk("arst_grant",  32'(grant[0]), 32'd0);
        chk("arst_acks",   {30'd0, ack[0][1], ack[0][0]}, 32'd0);
        chk("arst_rdata0", rdata[0][0],   32'd0);
        req[0][1] = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_busy", 32'(busy[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
